mem_arbiter: RTL

//  Sole owner of the byte-wide external RAM/IO port. Serves two requesters:
//  - icache miss refill: 4-byte instruction read, written back via update/inst/idx/tag.
//  - LSB: load/store of 1, 2 or 4 bytes.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial owner of the external RAM/IO port, shared between icache refills and LSB loads/stores.
// Handles arbitration, flush aborts and IO write-buffer back-pressure.
module mem_arbiter #(
   parameter int         ADDR_WIDTH  = 32,
   parameter int         INST_WIDTH  = 32,
   parameter int         INDEX_WIDTH = 4,
   parameter int         TAG_WIDTH   = 24,
   parameter logic [1:0] IO_PREFIX   = 2'b11
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   clear,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [ADDR_WIDTH-1:0]  mem_a,
   output logic                   mem_wr,
   input  logic                   io_buffer_full,
   input  logic                   upd_cache2mem_en,
   input  logic [ADDR_WIDTH-1:0]  cache2mem_PC,
   output logic                   update,
   output logic [INST_WIDTH-1:0]  mem2cache_inst,
   output logic [INDEX_WIDTH-1:0] mem2cache_idx,
   output logic [TAG_WIDTH-1:0]   mem2cache_tag,
   input  logic                   lsb_req,
   input  logic                   lsb_we,
   input  logic [1:0]             lsb_len,
   input  logic [ADDR_WIDTH-1:0]  lsb_addr,
   input  logic [31:0]            lsb_wdata,
   output logic                   lsb_done,
   output logic [31:0]            lsb_rdata
);

   // state  | meaning
   // IDLE   | waiting for a request; LSB wins over icache miss
   // IFETCH | reading 4 instruction bytes for an icache refill
   // LOAD   | reading 1/2/4 bytes for the LSB
   // STORE  | writing 1/2/4 bytes for the LSB, stalls on a full IO buffer
   // COOL   | one dead cycle so the requester can drop its level request
   typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, COOL} state_t;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q, data_d;
   logic [1:0]            cnt, last_q, next_cnt, req_last;
   logic                  wr_q, req_io, cur_io, stall, xfer_last, grant_lsb, grant_ic;

   always_comb begin
      state_d   = state;
      grant_lsb = 1'b0;
      grant_ic  = 1'b0;
      req_io    = (lsb_addr[17:16] == IO_PREFIX);
      cur_io    = (addr_q[17:16] == IO_PREFIX);
      stall     = (state == STORE) && cur_io && io_buffer_full;
      xfer_last = (cnt == last_q);
      next_cnt  = cnt + 2'd1;
      req_last  = (lsb_len == 2'd0) ? 2'd0 : (lsb_len == 2'd1) ? 2'd1 : 2'd3;
      data_d    = data_q;
      data_d[{cnt, 3'b000} +: 8] = mem_din;
      case (state)
         IDLE: begin
            if (!clear) begin
               if (lsb_req) begin
                  if (!(lsb_we && req_io && io_buffer_full)) begin
                     grant_lsb = 1'b1;
                     state_d   = lsb_we ? STORE : LOAD;
                  end
               end else if (upd_cache2mem_en) begin
                  grant_ic = 1'b1;
                  state_d  = IFETCH;
               end
            end
         end
         IFETCH, LOAD: begin
            if (clear)          state_d = IDLE;
            else if (xfer_last) state_d = COOL;
         end
         STORE:   if (!stall && xfer_last) state_d = COOL;
         COOL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The write strobe is gated combinationally so a freeze or a full IO buffer
   // takes effect in the very cycle it is seen.
   assign mem_wr = wr_q && rdy_in && !stall;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         addr_q         <= '0;
         data_q         <= '0;
         cnt            <= '0;
         last_q         <= '0;
         wr_q           <= 1'b0;
         mem_a          <= '0;
         mem_dout       <= '0;
         update         <= 1'b0;
         mem2cache_inst <= '0;
         mem2cache_idx  <= '0;
         mem2cache_tag  <= '0;
         lsb_done       <= 1'b0;
         lsb_rdata      <= '0;
      end else if (rdy_in) begin
         state    <= state_d;
         update   <= 1'b0;
         lsb_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_lsb) begin
                  addr_q   <= lsb_addr;
                  data_q   <= lsb_we ? lsb_wdata : 32'h0;
                  last_q   <= req_last;
                  cnt      <= 2'd0;
                  mem_a    <= lsb_addr;
                  wr_q     <= lsb_we;
                  mem_dout <= lsb_wdata[7:0];
               end else if (grant_ic) begin
                  addr_q <= cache2mem_PC;
                  data_q <= 32'h0;
                  last_q <= 2'd3;
                  cnt    <= 2'd0;
                  mem_a  <= cache2mem_PC;
                  wr_q   <= 1'b0;
               end
            end
            IFETCH, LOAD: begin
               if (!clear) begin
                  data_q <= data_d;
                  if (xfer_last) begin
                     if (state == IFETCH) begin
                        update         <= 1'b1;
                        mem2cache_inst <= data_d[INST_WIDTH-1:0];
                        mem2cache_idx  <= addr_q[4 +: INDEX_WIDTH];
                        mem2cache_tag  <= addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
                     end else begin
                        lsb_done  <= 1'b1;
                        lsb_rdata <= data_d;
                     end
                  end else begin
                     cnt   <= next_cnt;
                     mem_a <= addr_q + ADDR_WIDTH'(next_cnt);
                  end
               end
            end
            STORE: begin
               if (!stall) begin
                  if (xfer_last) begin
                     wr_q     <= 1'b0;
                     lsb_done <= 1'b1;
                  end else begin
                     cnt      <= next_cnt;
                     mem_a    <= addr_q + ADDR_WIDTH'(next_cnt);
                     mem_dout <= data_q[{next_cnt, 3'b000} +: 8];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
